// File: rtl/fpu_pkg.sv
// Shared types and constants for the fpu post-normalise/round/pack stage.
package fpu_pkg;

    localparam int unsigned EXP_W_DEF = 8;
    localparam int unsigned MAN_W_DEF = 23;
    localparam int unsigned BIAS      = (1 << (EXP_W_DEF - 1)) - 1;

    typedef enum logic [1:0] {
        StIdle,
        StNorm,
        StRound,
        StDone
    } state_e;

    localparam int unsigned ST_EXACT   = 0;
    localparam int unsigned ST_OVF     = 1;
    localparam int unsigned ST_UNF     = 2;
    localparam int unsigned ST_INEXACT = 3;

    typedef enum logic [1:0] {
        RmNearEven   = 2'b00,
        RmTowardZero = 2'b01,
        RmTowardPos  = 2'b10,
        RmTowardNeg  = 2'b11
    } rmode_e;

endpackage

// File: rtl/fpu_rounder.sv
// Combinational rounding: increment decision, carry into exponent, range check and packing.
module fpu_rounder
    import fpu_pkg::*;
#(
    parameter int unsigned EXP_W = EXP_W_DEF,
    parameter int unsigned MAN_W = MAN_W_DEF
) (
    input  logic                     sign_i,
    input  logic signed [EXP_W+2:0]  exp_i,
    input  logic [MAN_W+3:0]         man_i,
    input  rmode_e                   rmode_i,
    output logic [EXP_W+MAN_W:0]     result_o,
    output logic [3:0]               status_o
);

    localparam int unsigned XW = EXP_W + 3;
    localparam logic signed [XW-1:0] ExpInf = XW'((1 << EXP_W) - 1);
    localparam logic signed [XW-1:0] ExpOne = XW'(1);

    logic                   guard, round, sticky, lsb, lost, inc, carry, to_max;
    logic [MAN_W:0]         fsum;
    logic signed [XW-1:0]   exp_rnd;

    always_comb begin
        guard  = man_i[2];
        round  = man_i[1];
        sticky = man_i[0];
        lsb    = man_i[3];
        lost   = guard | round | sticky;

        inc = 1'b0;
        unique case (rmode_i)
            RmNearEven:   inc = guard & (round | sticky | lsb);
            RmTowardZero: inc = 1'b0;
            RmTowardPos:  inc = lost & ~sign_i;
            RmTowardNeg:  inc = lost & sign_i;
        endcase

        // Carry out of the fraction only overflows the significand when the hidden bit was set.
        fsum    = {1'b0, man_i[MAN_W+2:3]} + {{MAN_W{1'b0}}, inc};
        carry   = fsum[MAN_W] & man_i[MAN_W+3];
        exp_rnd = exp_i + $signed({{(XW-1){1'b0}}, carry});

        to_max = (rmode_i == RmTowardZero) || (rmode_i == RmTowardPos && sign_i) ||
                 (rmode_i == RmTowardNeg && !sign_i);

        result_o = {sign_i, exp_rnd[EXP_W-1:0], fsum[MAN_W-1:0]};
        status_o = '0;
        status_o[ST_INEXACT] = lost;
        status_o[ST_EXACT]   = ~lost;

        if (exp_rnd >= ExpInf) begin
            status_o = '0;
            status_o[ST_OVF]     = 1'b1;
            status_o[ST_INEXACT] = 1'b1;
            if (to_max) begin
                result_o = {sign_i, {(EXP_W-1){1'b1}}, 1'b0, {MAN_W{1'b1}}};
            end else begin
                result_o = {sign_i, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
            end
        end else if (exp_rnd < ExpOne) begin
            result_o = {sign_i, {(EXP_W+MAN_W){1'b0}}};
            status_o = '0;
            status_o[ST_UNF]     = 1'b1;
            status_o[ST_INEXACT] = 1'b1;
        end
    end

endmodule

// File: rtl/fpu_norm_round.sv
// Iterative normalise, round-to-nearest-even and pack stage with valid/ready on both sides.
// Define FPU_RMODE_EN to add the rmode port selecting one of four rounding modes.
module fpu_norm_round
    import fpu_pkg::*;
#(
    parameter int unsigned EXP_W = EXP_W_DEF,
    parameter int unsigned MAN_W = MAN_W_DEF
) (
    input  logic                    clock100KHz,
    input  logic                    reset,
`ifdef FPU_RMODE_EN
    input  logic [1:0]              rmode,
`endif
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic                    in_sign,
    input  logic [EXP_W+1:0]        in_exp,
    input  logic [MAN_W+4:0]        in_man,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [EXP_W+MAN_W:0]    result_out,
    output logic [3:0]              status_out
);

    localparam int unsigned XW = EXP_W + 3;
    localparam int unsigned MW = MAN_W + 5;
    localparam int unsigned RW = EXP_W + MAN_W + 1;
    localparam logic signed [XW-1:0] ExpOne = XW'(1);

    state_e                 state_q;
    logic                   sign_q;
    logic signed [XW-1:0]   exp_q;
    logic [MW-1:0]          man_q;
    logic [RW-1:0]          result_q;
    logic [3:0]             status_q;
    rmode_e                 rnd_mode;
    logic [RW-1:0]          rnd_result;
    logic [3:0]             rnd_status;

`ifdef FPU_RMODE_EN
    rmode_e rmode_q;

    always_ff @(posedge clock100KHz or negedge reset) begin
        if (!reset) begin
            rmode_q <= RmNearEven;
        end else if (state_q == StIdle && in_valid) begin
            rmode_q <= rmode_e'(rmode);
        end
    end

    assign rnd_mode = rmode_q;
`else
    assign rnd_mode = RmNearEven;
`endif

    always_ff @(posedge clock100KHz or negedge reset) begin
        if (!reset) begin
            state_q  <= StIdle;
            sign_q   <= 1'b0;
            exp_q    <= '0;
            man_q    <= '0;
            result_q <= '0;
            status_q <= '0;
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (in_valid) begin
                        sign_q  <= in_sign;
                        exp_q   <= {in_exp[EXP_W+1], in_exp};
                        man_q   <= in_man;
                        state_q <= StNorm;
                    end
                end
                StNorm: begin
                    if (man_q == '0) begin
                        result_q <= {sign_q, {(RW-1){1'b0}}};
                        status_q <= '0;
                        status_q[ST_EXACT] <= 1'b1;
                        state_q  <= StDone;
                    end else if (man_q[MW-1]) begin
                        // Right shift keeps the dropped bit alive in sticky.
                        man_q   <= {1'b0, man_q[MW-1:2], man_q[1] | man_q[0]};
                        exp_q   <= exp_q + ExpOne;
                        state_q <= StRound;
                    end else if (man_q[MW-2]) begin
                        state_q <= StRound;
                    end else if (exp_q <= ExpOne) begin
                        result_q <= {sign_q, {(RW-1){1'b0}}};
                        status_q <= '0;
                        status_q[ST_UNF]     <= 1'b1;
                        status_q[ST_INEXACT] <= 1'b1;
                        state_q  <= StDone;
                    end else begin
                        man_q <= {man_q[MW-2:0], 1'b0};
                        exp_q <= exp_q - ExpOne;
                    end
                end
                StRound: begin
                    result_q <= rnd_result;
                    status_q <= rnd_status;
                    state_q  <= StDone;
                end
                StDone: begin
                    if (out_ready) begin
                        state_q <= StIdle;
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    fpu_rounder #(
        .EXP_W (EXP_W),
        .MAN_W (MAN_W)
    ) u_rounder (
        .sign_i   (sign_q),
        .exp_i    (exp_q),
        .man_i    (man_q[MAN_W+3:0]),
        .rmode_i  (rnd_mode),
        .result_o (rnd_result),
        .status_o (rnd_status)
    );

    assign in_ready   = (state_q == StIdle);
    assign out_valid  = (state_q == StDone);
    assign result_out = result_q;
    assign status_out = status_q;

endmodule
